// File: rtl/ccu_pkg.sv
// Shared types for the CCU snoop port arbiter: snoop channel structs, domain mask,
// requester index and lock state.
package ccu_pkg;

  // Bit of the CR response flagging that CD data follows.
  localparam int unsigned CrDataTransferBit = 0;

  // Requester index: 0 = write path, 1 = read path.
  typedef logic snoop_arb_idx_t;

  typedef logic [3:0] domain_mask_t;
  typedef logic [4:0] cr_resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
  } ac_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic     ac_ready;
    logic     cr_valid;
    cr_resp_t cr_resp;
    logic     cd_valid;
    cd_chan_t cd;
  } snoop_resp_t;

  typedef enum logic [0:0] {StFree, StLocked} lock_state_e;

  // Round-robin successor of a two-way grant.
  function automatic snoop_arb_idx_t other_idx(snoop_arb_idx_t idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/ace_ccu_snoop_order_fifo.sv
// Small FIFO of requester indices used to track snoop response ordering.
// Push is ignored when full and pop when empty; a same-cycle pop never frees a slot
// for a push in that cycle.
module ace_ccu_snoop_order_fifo
  import ccu_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           push_i,
  input  snoop_arb_idx_t data_i,
  input  logic           pop_i,
  output logic           full_o,
  output logic           empty_o,
  output snoop_arb_idx_t head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  snoop_arb_idx_t [Depth-1:0] mem_q;
  logic [PtrW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]            cnt_q;
  logic                       push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push_ok && !pop_ok) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (!push_ok && pop_ok) begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/ace_ccu_snoop_port_arbiter.sv
// Shares one ACE snoop master port between the CCU write-path (0) and read-path (1)
// snoop controllers. AC is round-robin arbitrated with a lock while stalled; CR and CD
// are steered back to their originator through two order FIFOs.
// Optional per-requester AC grant counters: define ACE_CCU_SNOOP_ARB_STATS_EN.
module ace_ccu_snoop_port_arbiter
  import ccu_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned MaxCdPending   = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  snoop_req_t  [1:0]      slv_reqs_i,
  output snoop_resp_t [1:0]      slv_resps_o,
  input  domain_mask_t [1:0]     slv_masks_i,
  output snoop_req_t             mst_req_o,
  input  snoop_resp_t            mst_resp_i,
  output domain_mask_t           mst_mask_o,
  output logic [1:0][31:0]       stat_cnt_o
);

  logic           ord_full, ord_empty;
  snoop_arb_idx_t ord_head;
  logic           cd_full, cd_empty;
  snoop_arb_idx_t cd_head;

  lock_state_e    lock_q;
  snoop_arb_idx_t lock_idx_q, rr_ptr_q;

  logic [1:0]     eligible;
  snoop_arb_idx_t grant;
  logic           mst_ac_valid, ac_hs, cr_hs, cd_hs_last, cd_push;

  // Grant selection: a stalled AC keeps its grant, otherwise round-robin.
  always_comb begin
    eligible[0] = slv_reqs_i[0].ac_valid && !ord_full;
    eligible[1] = slv_reqs_i[1].ac_valid && !ord_full;
    if (lock_q == StLocked) begin
      grant = lock_idx_q;
    end else if (eligible == 2'b11) begin
      grant = rr_ptr_q;
    end else if (eligible[1]) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
  end

  assign mst_ac_valid = eligible[grant];
  assign ac_hs        = mst_ac_valid && mst_resp_i.ac_ready;
  assign cr_hs        = mst_resp_i.cr_valid && mst_req_o.cr_ready;
  assign cd_hs_last   = mst_resp_i.cd_valid && mst_req_o.cd_ready && mst_resp_i.cd.last;
  assign cd_push      = cr_hs && mst_resp_i.cr_resp[CrDataTransferBit];

  // Master-side request and mask muxing.
  always_comb begin
    mst_req_o          = '0;
    mst_req_o.ac_valid = mst_ac_valid;
    mst_req_o.ac       = slv_reqs_i[grant].ac;
    mst_req_o.cr_ready = !ord_empty && !cd_full && slv_reqs_i[ord_head].cr_ready;
    mst_req_o.cd_ready = !cd_empty && slv_reqs_i[cd_head].cd_ready;
    mst_mask_o         = slv_masks_i[grant];
  end

  // Response steering: AC ready to the grantee, CR/CD to their FIFO heads.
  always_comb begin
    slv_resps_o = '0;
    slv_resps_o[grant].ac_ready = mst_ac_valid && mst_resp_i.ac_ready;
    if (!ord_empty) begin
      // Hide CR from the requester while stalled on a full CD FIFO.
      slv_resps_o[ord_head].cr_valid = mst_resp_i.cr_valid && !cd_full;
      slv_resps_o[ord_head].cr_resp  = mst_resp_i.cr_resp;
    end
    if (!cd_empty) begin
      slv_resps_o[cd_head].cd_valid = mst_resp_i.cd_valid;
      slv_resps_o[cd_head].cd       = mst_resp_i.cd;
    end
  end

  // Grant lock and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= StFree;
      lock_idx_q <= 1'b0;
      rr_ptr_q   <= 1'b0;
    end else begin
      if (ac_hs) begin
        lock_q   <= StFree;
        rr_ptr_q <= other_idx(grant);
      end else if (mst_ac_valid) begin
        lock_q     <= StLocked;
        lock_idx_q <= grant;
      end
    end
  end

  ace_ccu_snoop_order_fifo #(
    .Depth (MaxOutstanding)
  ) i_order_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (ac_hs),
    .data_i  (grant),
    .pop_i   (cr_hs),
    .full_o  (ord_full),
    .empty_o (ord_empty),
    .head_o  (ord_head)
  );

  ace_ccu_snoop_order_fifo #(
    .Depth (MaxCdPending)
  ) i_cd_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cd_push),
    .data_i  (ord_head),
    .pop_i   (cd_hs_last),
    .full_o  (cd_full),
    .empty_o (cd_empty),
    .head_o  (cd_head)
  );

`ifdef ACE_CCU_SNOOP_ARB_STATS_EN
  logic [1:0][31:0] stat_cnt_q, stat_cnt_d;

  // Saturating count of AC handshakes per requester.
  always_comb begin
    stat_cnt_d = stat_cnt_q;
    if (ac_hs && (stat_cnt_q[grant] != '1)) begin
      stat_cnt_d[grant] = stat_cnt_q[grant] + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_cnt_q <= '0;
    end else begin
      stat_cnt_q <= stat_cnt_d;
    end
  end

  assign stat_cnt_o = stat_cnt_q;
`else
  assign stat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ace_ccu_snoop_port_arbiter.sv
// Directed bench for ace_ccu_snoop_port_arbiter (MaxOutstanding=4, MaxCdPending=2).
module tb_ace_ccu_snoop_port_arbiter;
  import ccu_pkg::*;

  logic               clk_i;
  logic               rst_ni;
  snoop_req_t  [1:0]  slv_reqs;
  snoop_resp_t [1:0]  slv_resps;
  domain_mask_t [1:0] slv_masks;
  snoop_req_t         mst_req;
  snoop_resp_t        mst_resp;
  domain_mask_t       mst_mask;
  logic [1:0][31:0]   stat_cnt;

  int errors = 0;
  int checks = 0;
  int exp_w, exp_r;

  ace_ccu_snoop_port_arbiter #(
    .MaxOutstanding (4),
    .MaxCdPending   (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .slv_reqs_i  (slv_reqs),
    .slv_resps_o (slv_resps),
    .slv_masks_i (slv_masks),
    .mst_req_o   (mst_req),
    .mst_resp_i  (mst_resp),
    .mst_mask_o  (mst_mask),
    .stat_cnt_o  (stat_cnt)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni    = 1'b0;
    slv_reqs  = '0;
    mst_resp  = '0;
    slv_masks = '0;
    slv_masks[0] = 4'h1;
    slv_masks[1] = 4'h2;
    #12;
    // Reset state
    chk("rst_ac_valid", mst_req.ac_valid, 0);
    chk("rst_cr_ready", mst_req.cr_ready, 0);
    chk("rst_cd_ready", mst_req.cd_ready, 0);
    chk("rst_resp0", slv_resps[0], 0);
    chk("rst_resp1", slv_resps[1], 0);
    chk("rst_stat", stat_cnt, 0);
    rst_ni = 1'b1;

    // 1: simultaneous ACs, write first then read; CRs in order
    slv_reqs[0].ac_valid = 1'b1; slv_reqs[0].ac.addr = 32'h100;
    slv_reqs[1].ac_valid = 1'b1; slv_reqs[1].ac.addr = 32'h200;
    mst_resp.ac_ready = 1'b1;
    #1;
    chk("t1_valid", mst_req.ac_valid, 1);
    chk("t1_addr_w", mst_req.ac.addr, 32'h100);
    chk("t1_mask_w", mst_mask, 4'h1);
    chk("t1_rdy0", slv_resps[0].ac_ready, 1);
    chk("t1_rdy1_off", slv_resps[1].ac_ready, 0);
    tick();
    slv_reqs[0].ac_valid = 1'b0;
    #1;
    chk("t1_addr_r", mst_req.ac.addr, 32'h200);
    chk("t1_mask_r", mst_mask, 4'h2);
    chk("t1_rdy1", slv_resps[1].ac_ready, 1);
    tick();
    slv_reqs[1].ac_valid = 1'b0;
    mst_resp.cr_valid = 1'b1; mst_resp.cr_resp = 5'b00000;
    slv_reqs[0].cr_ready = 1'b1; slv_reqs[1].cr_ready = 1'b1;
    #1;
    chk("t1_cr0_v0", slv_resps[0].cr_valid, 1);
    chk("t1_cr0_v1", slv_resps[1].cr_valid, 0);
    chk("t1_cr0_rdy", mst_req.cr_ready, 1);
    tick();
    chk("t1_cr1_v1", slv_resps[1].cr_valid, 1);
    chk("t1_cr1_v0", slv_resps[0].cr_valid, 0);
    tick();
    chk("t1_empty_cr_rdy", mst_req.cr_ready, 0);
    chk("t1_empty_cr_v", slv_resps[0].cr_valid, 0);
    mst_resp.cr_valid = 1'b0;

    // 2: lock. First a write handshake sets the pointer to read.
    slv_reqs[0].ac_valid = 1'b1; slv_reqs[0].ac.addr = 32'h250;
    #1;
    chk("t2_pre_addr", mst_req.ac.addr, 32'h250);
    tick();
    slv_reqs[0].ac.addr = 32'h300;
    mst_resp.ac_ready = 1'b0;
    #1;
    chk("t2_stall0_addr", mst_req.ac.addr, 32'h300);
    tick();
    slv_reqs[1].ac_valid = 1'b1; slv_reqs[1].ac.addr = 32'h400;
    #1;
    chk("t2_stall1_addr", mst_req.ac.addr, 32'h300);
    chk("t2_stall1_mask", mst_mask, 4'h1);
    chk("t2_stall1_rdy1", slv_resps[1].ac_ready, 0);
    tick();
    chk("t2_stall2_addr", mst_req.ac.addr, 32'h300);
    chk("t2_stall2_valid", mst_req.ac_valid, 1);
    mst_resp.ac_ready = 1'b1;
    #1;
    chk("t2_rel_rdy0", slv_resps[0].ac_ready, 1);
    chk("t2_rel_rdy1", slv_resps[1].ac_ready, 0);
    tick();
    slv_reqs[0].ac_valid = 1'b0;
    #1;
    chk("t2_read_addr", mst_req.ac.addr, 32'h400);
    chk("t2_read_rdy1", slv_resps[1].ac_ready, 1);
    tick();
    slv_reqs[1].ac_valid = 1'b0;

    // 3: fill order FIFO (entries 0,0,1 + this write), then full behaviour
    slv_reqs[0].ac_valid = 1'b1; slv_reqs[0].ac.addr = 32'h500;
    #1;
    chk("t3_4th_rdy", slv_resps[0].ac_ready, 1);
    tick();
    slv_reqs[0].ac_valid = 1'b0;
    slv_reqs[1].ac_valid = 1'b1; slv_reqs[1].ac.addr = 32'h600;
    mst_resp.cr_valid = 1'b1; mst_resp.cr_resp = 5'b00000;
    #1;
    chk("t3_full_valid", mst_req.ac_valid, 0);
    chk("t3_full_rdy1", slv_resps[1].ac_ready, 0);
    chk("t3_full_cr_rdy", mst_req.cr_ready, 1);
    chk("t3_full_cr_v0", slv_resps[0].cr_valid, 1);
    tick();
    mst_resp.cr_valid = 1'b0;
    #1;
    chk("t3_5th_valid", mst_req.ac_valid, 1);
    chk("t3_5th_addr", mst_req.ac.addr, 32'h600);
    chk("t3_5th_rdy1", slv_resps[1].ac_ready, 1);
    tick();
    slv_reqs[1].ac_valid = 1'b0;
    // Order FIFO now holds 0,1,0,1.

    // 4/5: write CR without data, then read CR with data and a 2-beat CD
    mst_resp.cr_valid = 1'b1; mst_resp.cr_resp = 5'b00000;
    mst_resp.cd_valid = 1'b1; mst_resp.cd.data = 32'hAA; mst_resp.cd.last = 1'b0;
    slv_reqs[0].cd_ready = 1'b1; slv_reqs[1].cd_ready = 1'b1;
    #1;
    chk("t4_crw_v0", slv_resps[0].cr_valid, 1);
    chk("t4_early_cd_rdy", mst_req.cd_ready, 0);
    chk("t4_early_cd_v1", slv_resps[1].cd_valid, 0);
    tick();
    mst_resp.cr_resp = 5'b00001;
    #1;
    chk("t4_crr_v1", slv_resps[1].cr_valid, 1);
    chk("t4_crr_resp", slv_resps[1].cr_resp, 5'b00001);
    chk("t4_crr_v0", slv_resps[0].cr_valid, 0);
    chk("t4_crr_cd_rdy", mst_req.cd_ready, 0);
    tick();
    mst_resp.cr_valid = 1'b0;
    #1;
    chk("t4_b0_rdy", mst_req.cd_ready, 1);
    chk("t4_b0_v1", slv_resps[1].cd_valid, 1);
    chk("t4_b0_data", slv_resps[1].cd.data, 32'hAA);
    chk("t4_b0_v0", slv_resps[0].cd_valid, 0);
    tick();
    mst_resp.cd.data = 32'hBB; mst_resp.cd.last = 1'b1;
    #1;
    chk("t4_b1_v1", slv_resps[1].cd_valid, 1);
    chk("t4_b1_last", slv_resps[1].cd.last, 1);
    chk("t4_b1_data", slv_resps[1].cd.data, 32'hBB);
    tick();
    chk("t4_done_cd_rdy", mst_req.cd_ready, 0);
    chk("t4_done_cd_v1", slv_resps[1].cd_valid, 0);
    mst_resp.cd_valid = 1'b0;

    // 6: statistics (writes 0x100,0x250,0x300,0x500; reads 0x200,0x400,0x600)
`ifdef ACE_CCU_SNOOP_ARB_STATS_EN
    exp_w = 4; exp_r = 3;
`else
    exp_w = 0; exp_r = 0;
`endif
    chk("t6_stat_w", stat_cnt[0], 64'(exp_w));
    chk("t6_stat_r", stat_cnt[1], 64'(exp_r));

    // One more write moves the pointer to read before the reset.
    slv_reqs[0].ac_valid = 1'b1; slv_reqs[0].ac.addr = 32'h700;
    tick();
    slv_reqs[0].ac_valid = 1'b0;
    mst_resp.cr_valid = 1'b1; mst_resp.cr_resp = 5'b00000;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst2_stat", stat_cnt, 0);
    chk("rst2_cr_rdy", mst_req.cr_ready, 0);
    chk("rst2_cr_v0", slv_resps[0].cr_valid, 0);
    rst_ni = 1'b1;
    #1;
    chk("rst2_fifo_empty", mst_req.cr_ready, 0);
    mst_resp.cr_valid = 1'b0;
    slv_reqs[0].ac_valid = 1'b1; slv_reqs[0].ac.addr = 32'h800;
    slv_reqs[1].ac_valid = 1'b1; slv_reqs[1].ac.addr = 32'h900;
    #1;
    chk("rst2_ptr_addr", mst_req.ac.addr, 32'h800);
    tick();
    slv_reqs = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
